gj_sequencer: RTL and testbench
===============================

GJ_SEQUENCER -- requirements
Module: gj_sequencer

Interface
REQ-001 Parameter N, 5, matrix order (2..8).
REQ-002 Parameter W, 32, element width, signed two's-complement fixed point.
REQ-003 Parameter FRAC, 16, fractional bits of the element format (Q(W-FRAC).FRAC).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to invert the loaded matrix; sampled only in IDLE.
REQ-008 wr_en / wr_row / wr_col / wr_data  in  1 / clog2(N) / clog2(N) / W  load A[row][col]; honoured only in IDLE.
REQ-009 rd_row / rd_col  in  clog2(N) each  result read address.
REQ-010 rd_data  out  W  combinational read of inverse element [rd_row][rd_col], i.e. augmented column N+rd_col.
REQ-011 busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-012 done  out  1  one-cycle pulse at completion.
REQ-013 singular  out  1  valid with done; held until the next accepted start.

Function
REQ-014 The block SHALL hold an N x 2N augmented register array; on start acceptance, columns N..2N-1 SHALL be set to identity in the same cycle.
REQ-015 FSM states SHALL be IDLE, PIVOT, RECIP, NORM, ELIM_K, ELIM, DONE.
REQ-016 PIVOT (1 cycle): if A[p][p]==0, go to DONE with singular=1, else go to RECIP.
REQ-017 RECIP: the sub-module computes 1/A[p][p] in W cycles, then goes to NORM.
REQ-018 NORM: one element per cycle, A[p][c] = A[p][c]*recip for c=0..2N-1 (2N cycles).
REQ-019 ELIM_K (1 cycle per row r != p, ascending r): latch k=A[r][p].
REQ-020 ELIM (2N cycles per row): A[r][c] = A[r][c] - k*A[p][c].
REQ-021 After the last row, p increments; p==N goes to DONE; DONE (1 cycle) pulses done, then IDLE.
REQ-022 Products SHALL be 2W bits wide, keep bits [W+FRAC-1:FRAC] with arithmetic truncation, and saturate to the W-bit signed range; subtraction SHALL also saturate.
REQ-023 Non-singular latency from start acceptance to done SHALL be N*(W+2N+1+(N-1)*(2N+1))+2 cycles (437 at defaults).
REQ-024 start while busy SHALL be ignored; wr_en while busy SHALL be ignored; start and wr_en in the same IDLE cycle: the write lands first, then the run begins.

Reset
REQ-025 On rst_n low, at any time including mid-run: state=IDLE, p=0, array cleared to 0, busy=0, done=0, singular=0, and the divider is flushed.

Configuration
REQ-026 With GJ_ROW_SWAP_EN defined, PIVOT with a zero pivot SHALL search rows p+1..N-1 (1 cycle per row), swap the first non-zero row with row p in one cycle, then go to RECIP; singular=1 only if none is found. Each swap adds (rows searched + 1) cycles to latency.
REQ-027 Without GJ_ROW_SWAP_EN, behaviour SHALL be exactly REQ-016.

Structure
REQ-028 Package gj_pkg SHALL hold the state enum, the saturating fixed-point multiply/subtract functions, and default N/W/FRAC constants.
REQ-029 Sub-module gj_recip SHALL be a sequential signed restoring divider (start/valid, W-cycle latency) computing 2^(2*FRAC)/pivot.

Verification
REQ-030 Identity loaded, start -> done at cycle 437, singular=0, rd_data equals identity (0x00010000 on the diagonal, 0 elsewhere).
REQ-031 diag(2,4,8,16,32) -> inverse diagonal 0x00008000, 0x00004000, 0x00002000, 0x00001000, 0x00000800.
REQ-032 Row 2 all zeros -> done with singular=1; busy drops after the done cycle.
REQ-033 Permutation matrix (rows 0 and 1 swapped) -> with GJ_ROW_SWAP_EN: singular=0, inverse equals the transpose; without it: singular=1 at the first pivot.
REQ-034 rst_n low at cycle 200 of a run -> busy=0 immediately; the array reads 0; a fresh load and start complete correctly.
REQ-035 Second start and wr_en pulses mid-run -> ignored; result unchanged; exactly one done pulse.

Source files
------------

// File: rtl/gj_pkg.sv
// Shared types and saturating fixed-point helpers for the Gauss-Jordan inverter.
package gj_pkg;

    localparam int GJ_N    = 5;
    localparam int GJ_W    = 32;
    localparam int GJ_FRAC = 16;
    localparam int GJ_XW   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIVOT,
        ST_RECIP,
        ST_NORM,
        ST_ELIM_K,
        ST_ELIM,
        ST_DONE
    } gj_state_e;

    function automatic logic signed [GJ_XW-1:0] fx_sat(input logic signed [2*GJ_XW-1:0] v,
                                                       input int w);
        logic signed [2*GJ_XW-1:0] hi;
        logic signed [2*GJ_XW-1:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (v > hi)
            fx_sat = GJ_XW'(hi);
        else if (v < lo)
            fx_sat = GJ_XW'(lo);
        else
            fx_sat = GJ_XW'(v);
    endfunction

    // Full-width product, arithmetic shift drops FRAC bits (floor), then clamp to w bits.
    function automatic logic signed [GJ_XW-1:0] fx_mul(input logic signed [GJ_XW-1:0] a,
                                                       input logic signed [GJ_XW-1:0] b,
                                                       input int w,
                                                       input int frac);
        logic signed [2*GJ_XW-1:0] prod;
        prod   = (2*GJ_XW)'(a) * (2*GJ_XW)'(b);
        fx_mul = fx_sat(prod >>> frac, w);
    endfunction

    function automatic logic signed [GJ_XW-1:0] fx_sub(input logic signed [GJ_XW-1:0] a,
                                                       input logic signed [GJ_XW-1:0] b,
                                                       input int w);
        fx_sub = fx_sat((2*GJ_XW)'(a) - (2*GJ_XW)'(b), w);
    endfunction

endpackage

// File: rtl/gj_recip.sv
// Sequential restoring divider producing the saturated fixed-point reciprocal 2^(2*FRAC)/pivot.
module gj_recip
    import gj_pkg::*;
#(
    parameter int W    = GJ_W,
    parameter int FRAC = GJ_FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] pivot,
    output logic                valid,
    output logic signed [W-1:0] recip
);

    localparam int CNTW = $clog2(W + 1);
    localparam logic [2*W-1:0] DIVIDEND = (2*W)'(1) << (2 * FRAC);
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic [CNTW-1:0] cnt;
    logic [W-1:0]    rem, lo, q, dvs, mag;
    logic [W-1:0]    rem_nxt, q_nxt;
    logic [W:0]      trial;
    logic            qbit, neg, ovf;

    assign mag = pivot[W-1] ? W'(-pivot) : W'(pivot);

    // valid marks the cycle whose closing edge writes the final quotient into recip
    assign valid = (cnt == CNTW'(1));

    always_comb begin
        trial   = {rem, lo[W-1]};
        qbit    = (trial >= {1'b0, dvs});
        rem_nxt = qbit ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
        q_nxt   = {q[W-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start)
            cnt <= CNTW'(W);
        else if (cnt != '0)
            cnt <= cnt - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem <= DIVIDEND[2*W-1:W];
            lo  <= DIVIDEND[W-1:0];
            q   <= '0;
            dvs <= mag;
            neg <= pivot[W-1];
            ovf <= (DIVIDEND[2*W-1:W] >= mag);
        end else if (cnt != '0) begin
            rem <= rem_nxt;
            lo  <= lo << 1;
            q   <= q_nxt;
            if (valid) begin
                if (ovf || q_nxt[W-1])
                    recip <= neg ? SMIN : SMAX;
                else
                    recip <= neg ? -q_nxt : q_nxt;
            end
        end
    end

endmodule

// File: rtl/gj_sequencer.sv
// Gauss-Jordan matrix inverter over an N x 2N augmented register array.
// Optional GJ_ROW_SWAP_EN: on a zero pivot, search lower rows and swap in the first non-zero one.
module gj_sequencer
    import gj_pkg::*;
#(
    parameter int N    = GJ_N,
    parameter int W    = GJ_W,
    parameter int FRAC = GJ_FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    wr_en,
    input  logic [$clog2(N)-1:0]    wr_row,
    input  logic [$clog2(N)-1:0]    wr_col,
    input  logic signed [W-1:0]     wr_data,
    input  logic [$clog2(N)-1:0]    rd_row,
    input  logic [$clog2(N)-1:0]    rd_col,
    output logic signed [W-1:0]     rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    singular
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N + 1);
    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] CLAST = CW'(2 * N - 1);
    localparam logic signed [W-1:0] ONE = W'(1) << FRAC;

    gj_state_e state, state_nxt;
    logic [PW-1:0] p, p_nxt, r, r_nxt;
    logic [CW-1:0] c, c_nxt;
    logic [IW-1:0] pi, ri;
    logic busy_q, done_q, sing_q;
    logic start_acc, host_we, norm_we, elim_we, k_we, sing_set, div_start, div_valid;
    logic signed [W-1:0] arr [N][2*N];
    logic signed [W-1:0] piv, div_pivot, recip, k, norm_val, elim_val;
    int rn;

`ifdef GJ_ROW_SWAP_EN
    logic          srch, srch_nxt, swp, swp_nxt, swap_do;
    logic [IW-1:0] s, s_nxt;
    logic signed [W-1:0] cand;
    assign cand = arr[s][CW'(pi)];
`endif

    assign pi        = p[IW-1:0];
    assign ri        = r[IW-1:0];
    assign piv       = arr[pi][CW'(pi)];
    assign start_acc = start && (state == ST_IDLE) && !busy_q;
    assign host_we   = wr_en && (state == ST_IDLE) && !busy_q;
    assign norm_val  = W'(fx_mul(GJ_XW'(arr[pi][c]), GJ_XW'(recip), W, FRAC));
    assign elim_val  = W'(fx_sub(GJ_XW'(arr[ri][c]),
                                 fx_mul(GJ_XW'(k), GJ_XW'(arr[pi][c]), W, FRAC), W));
    assign rd_data   = arr[rd_row][CW'(N) + CW'(rd_col)];
    assign busy      = busy_q;
    assign done      = done_q;
    assign singular  = sing_q;

    gj_recip #(.W(W), .FRAC(FRAC)) u_recip (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .pivot (div_pivot),
        .valid (div_valid),
        .recip (recip)
    );

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        r_nxt     = r;
        c_nxt     = c;
        div_start = 1'b0;
        div_pivot = piv;
        sing_set  = 1'b0;
        norm_we   = 1'b0;
        elim_we   = 1'b0;
        k_we      = 1'b0;
        rn        = 0;
`ifdef GJ_ROW_SWAP_EN
        srch_nxt  = srch;
        swp_nxt   = swp;
        s_nxt     = s;
        swap_do   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start_acc) begin
                    state_nxt = ST_PIVOT;
                    p_nxt     = '0;
                end
            end
            ST_PIVOT: begin
`ifdef GJ_ROW_SWAP_EN
                if (swp) begin
                    swap_do   = 1'b1;
                    div_start = 1'b1;
                    div_pivot = cand;
                    swp_nxt   = 1'b0;
                    srch_nxt  = 1'b0;
                    state_nxt = ST_RECIP;
                end else if (srch) begin
                    if (cand != '0) begin
                        swp_nxt = 1'b1;
                    end else if (s == IW'(N - 1)) begin
                        srch_nxt  = 1'b0;
                        sing_set  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        s_nxt = s + IW'(1);
                    end
                end else if (piv != '0) begin
                    div_start = 1'b1;
                    state_nxt = ST_RECIP;
                end else if (p == PW'(N - 1)) begin
                    sing_set  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    srch_nxt = 1'b1;
                    s_nxt    = pi + IW'(1);
                end
`else
                if (piv == '0) begin
                    sing_set  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    div_start = 1'b1;
                    state_nxt = ST_RECIP;
                end
`endif
            end
            ST_RECIP: begin
                if (div_valid) begin
                    c_nxt     = '0;
                    state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                norm_we = 1'b1;
                if (c == CLAST) begin
                    c_nxt     = '0;
                    r_nxt     = (p == '0) ? PW'(1) : '0;
                    state_nxt = ST_ELIM_K;
                end else begin
                    c_nxt = c + CW'(1);
                end
            end
            ST_ELIM_K: begin
                k_we      = 1'b1;
                c_nxt     = '0;
                state_nxt = ST_ELIM;
            end
            ST_ELIM: begin
                elim_we = 1'b1;
                if (c == CLAST) begin
                    c_nxt = '0;
                    rn    = int'(r) + 1;
                    if (rn == int'(p))
                        rn = rn + 1;
                    if (rn >= N) begin
                        p_nxt     = p + PW'(1);
                        state_nxt = (p == PW'(N - 1)) ? ST_DONE : ST_PIVOT;
                    end else begin
                        r_nxt     = PW'(rn);
                        state_nxt = ST_ELIM_K;
                    end
                end else begin
                    c_nxt = c + CW'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            p      <= '0;
            r      <= '0;
            c      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sing_q <= 1'b0;
`ifdef GJ_ROW_SWAP_EN
            srch   <= 1'b0;
            swp    <= 1'b0;
            s      <= '0;
`endif
        end else begin
            state  <= state_nxt;
            p      <= p_nxt;
            r      <= r_nxt;
            c      <= c_nxt;
            // busy/done are registered so the done cycle directly follows DONE
            busy_q <= (state_nxt != ST_IDLE) || (state == ST_DONE);
            done_q <= (state == ST_DONE);
            if (start_acc)
                sing_q <= 1'b0;
            else if (sing_set)
                sing_q <= 1'b1;
`ifdef GJ_ROW_SWAP_EN
            srch   <= srch_nxt;
            swp    <= swp_nxt;
            s      <= s_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (k_we)
            k <= arr[ri][CW'(pi)];
    end

    // Host write precedes the identity load so a same-cycle write and start both land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < 2 * N; j++)
                    arr[i][j] <= '0;
        end else begin
            if (host_we)
                arr[wr_row][CW'(wr_col)] <= wr_data;
            if (start_acc)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        arr[i][N + j] <= (i == j) ? ONE : '0;
            if (norm_we)
                arr[pi][c] <= norm_val;
            if (elim_we)
                arr[ri][c] <= elim_val;
`ifdef GJ_ROW_SWAP_EN
            if (swap_do)
                for (int j = 0; j < 2 * N; j++) begin
                    arr[pi][j] <= arr[s][j];
                    arr[s][j]  <= arr[pi][j];
                end
`endif
        end
    end

endmodule

// File: tb/tb_gj_sequencer.sv
// Directed bench for gj_sequencer; expectations follow the GJ_ROW_SWAP_EN build setting.
module tb_gj_sequencer;

    localparam int N    = 5;
    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int AW   = 3;
    localparam logic [W-1:0] ONE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  rd_data;
    logic          busy, done, singular;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] m [N][N];

    always #5 clk = ~clk;

    gj_sequencer #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .singular (singular)
    );

    task automatic set_identity();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = (i == j) ? ONE : '0;
    endtask

    task automatic load_matrix();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                @(posedge clk);
                #1;
                wr_en   = 1'b1;
                wr_row  = AW'(i);
                wr_col  = AW'(j);
                wr_data = m[i][j];
            end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input int r, input int c, output logic [W-1:0] v);
        rd_row = AW'(r);
        rd_col = AW'(c);
        #1;
        v = rd_data;
    endtask

    // Pulses start; returns the cycle (1 = first cycle after acceptance) at which done is seen.
    task automatic run(output int lat);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: done not seen within 1000 cycles");
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (singular !== 1'b0) begin errors++; $display("FAIL reset_singular: got %b want 0", singular); end
        rd(0, 0, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL reset_rd00: got %h want 0", v); end
        rd(4, 4, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL reset_rd44: got %h want 0", v); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lat;
        logic [W-1:0] v, e;
        set_identity();
        load_matrix();
        run(lat);
        checks++; if (lat != 437) begin errors++; $display("FAIL ident_latency: got %0d want 437", lat); end
        checks++; if (singular !== 1'b0) begin errors++; $display("FAIL ident_singular: got %b want 0", singular); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ident_busy_done: got %b want 1", busy); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                e = (i == j) ? 32'h0001_0000 : 32'h0;
                rd(i, j, v);
                checks++;
                if (v !== e) begin errors++; $display("FAIL ident_rd[%0d][%0d]: got %h want %h", i, j, v, e); end
            end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ident_busy_after: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ident_done_pulse: got %b want 0", done); end
    endtask

    task automatic load_diag();
        set_identity();
        for (int i = 0; i < N; i++)
            m[i][i] = 32'h1 << (17 + i);
        load_matrix();
    endtask

    task automatic test_diag();
        int lat;
        logic [W-1:0] v;
        logic [W-1:0] exp_d [N];
        exp_d = '{32'h0000_8000, 32'h0000_4000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0800};
        load_diag();
        run(lat);
        checks++; if (lat != 437) begin errors++; $display("FAIL diag_latency: got %0d want 437", lat); end
        for (int i = 0; i < N; i++) begin
            rd(i, i, v);
            checks++;
            if (v !== exp_d[i]) begin errors++; $display("FAIL diag_rd[%0d]: got %h want %h", i, v, exp_d[i]); end
        end
        rd(0, 4, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL diag_offdiag: got %h want 0", v); end
    endtask

    task automatic load_general();
        set_identity();
        m[0][0] = 32'hFFFE_0000;
        m[1][0] = ONE;
        load_matrix();
    endtask

    task automatic test_general();
        int lat;
        logic [W-1:0] v;
        load_general();
        run(lat);
        checks++; if (lat != 437) begin errors++; $display("FAIL gen_latency: got %0d want 437", lat); end
        rd(0, 0, v);
        checks++; if (v !== 32'hFFFF_8000) begin errors++; $display("FAIL gen_rd00: got %h want ffff8000", v); end
        rd(1, 0, v);
        checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL gen_rd10: got %h want 00008000", v); end
        rd(1, 1, v);
        checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL gen_rd11: got %h want 00010000", v); end
        rd(0, 1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL gen_rd01: got %h want 0", v); end
    endtask

    task automatic test_saturation();
        int lat;
        logic [W-1:0] v;
        set_identity();
        m[0][0] = 32'h0000_0001;
        load_matrix();
        run(lat);
        rd(0, 0, v);
        checks++; if (v !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_rd00: got %h want 7fffffff", v); end
        rd(1, 1, v);
        checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL sat_rd11: got %h want 00010000", v); end
    endtask

    task automatic test_singular();
        int lat, exp_lat;
        set_identity();
        for (int j = 0; j < N; j++)
            m[2][j] = '0;
        load_matrix();
`ifdef GJ_ROW_SWAP_EN
        exp_lat = 179;
`else
        exp_lat = 177;
`endif
        run(lat);
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL sing_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (singular !== 1'b1) begin errors++; $display("FAIL sing_flag: got %b want 1", singular); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sing_busy_done: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sing_busy_after: got %b want 0", busy); end
        checks++; if (singular !== 1'b1) begin errors++; $display("FAIL sing_held: got %b want 1", singular); end
    endtask

    task automatic test_perm();
        int lat;
        logic [W-1:0] v;
        set_identity();
        m[0][0] = '0; m[0][1] = ONE;
        m[1][0] = ONE; m[1][1] = '0;
        load_matrix();
        run(lat);
`ifdef GJ_ROW_SWAP_EN
        checks++; if (lat != 439) begin errors++; $display("FAIL perm_latency: got %0d want 439", lat); end
        checks++; if (singular !== 1'b0) begin errors++; $display("FAIL perm_singular: got %b want 0", singular); end
        rd(0, 1, v);
        checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL perm_rd01: got %h want 00010000", v); end
        rd(1, 0, v);
        checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL perm_rd10: got %h want 00010000", v); end
        rd(0, 0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL perm_rd00: got %h want 0", v); end
        rd(2, 2, v);
        checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL perm_rd22: got %h want 00010000", v); end
`else
        checks++; if (lat != 3) begin errors++; $display("FAIL perm_latency: got %0d want 3", lat); end
        checks++; if (singular !== 1'b1) begin errors++; $display("FAIL perm_singular: got %b want 1", singular); end
        rd(0, 0, v);
`endif
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic [W-1:0] v;
        load_diag();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", done); end
        rd(0, 0, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL mid_rst_rd00: got %h want 0", v); end
        rd(3, 3, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL mid_rst_rd33: got %h want 0", v); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_diag();
        run(lat);
        checks++; if (lat != 437) begin errors++; $display("FAIL mid_rerun_latency: got %0d want 437", lat); end
        rd(2, 2, v);
        checks++; if (v !== 32'h0000_2000) begin errors++; $display("FAIL mid_rerun_rd22: got %h want 00002000", v); end
    endtask

    task automatic test_back_to_back();
        int dones, first;
        logic [W-1:0] v;
        load_general();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 470; n++) begin
            @(negedge clk);
            if (n == 50) begin
                start = 1'b1; wr_en = 1'b1; wr_row = '0; wr_col = '0; wr_data = 32'h0;
            end else if (n == 51) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
        checks++; if (first != 437) begin errors++; $display("FAIL b2b_latency: got %0d want 437", first); end
        rd(0, 0, v);
        checks++; if (v !== 32'hFFFF_8000) begin errors++; $display("FAIL b2b_rd00: got %h want ffff8000", v); end
        rd(1, 0, v);
        checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL b2b_rd10: got %h want 00008000", v); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_diag();
        test_general();
        test_saturation();
        test_singular();
        test_perm();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
